// File: rtl/param_alu.sv
// Parametrised ALU with a start/done handshake: single-cycle logic/ADD/SUB,
// plus an iterative shift-add multiplier that takes WIDTH cycles.
module param_alu #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           op,
    input  logic                 start,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic                 err
);
    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [CW-1:0]    r_cnt;
    logic [RW-1:0]    r_acc;
    logic [RW-1:0]    r_mcand;
    logic [RW-1:0]    w_acc_next;
    logic [RW-1:0]    w_exec_res;
    logic             w_exec_err;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_last;

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (start) w_next = (op == OP_MUL) ? S_MUL : S_EXEC;
            S_EXEC: w_next = S_IDLE;
            S_MUL:  if (w_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};

    always_comb begin
        w_exec_res = result;
        w_exec_err = 1'b0;
        unique case (r_op)
            OP_NOP: w_exec_res = result;
            OP_ADD: w_exec_res = {{(WIDTH-1){1'b0}}, w_sum};
            OP_AND: w_exec_res = {{WIDTH{1'b0}}, r_a & r_b};
            OP_XOR: w_exec_res = {{WIDTH{1'b0}}, r_a ^ r_b};
            OP_SUB: w_exec_res = {{(WIDTH-1){w_diff[WIDTH]}}, w_diff};
            default: begin
                w_exec_res = '0;
                w_exec_err = 1'b1;
            end
        endcase
    end

    // Multiplier bits are consumed LSB first from r_b while r_mcand shifts up.
    assign w_acc_next = r_acc + (r_b[0] ? r_mcand : '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mcand <= '0;
            result  <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_op    <= op;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_mcand <= {{WIDTH{1'b0}}, A};
                        busy    <= 1'b1;
                    end
                end
                S_EXEC: begin
                    result <= w_exec_res;
                    err    <= w_exec_err;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end
                S_MUL: begin
                    r_acc   <= w_acc_next;
                    r_mcand <= r_mcand << 1;
                    r_b     <= r_b >> 1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        result <= w_acc_next;
                        err    <= 1'b0;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        r_cnt  <= '0;
                    end
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_param_alu.sv
// Scoreboard bench for param_alu: WIDTH=8 and WIDTH=16 instances side by side.
module tb_param_alu;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [7:0]  a8, b8;
    logic [2:0]  op8;
    logic        start8, done8, busy8, err8;
    logic [15:0] res8;

    logic [15:0] a16, b16;
    logic [2:0]  op16;
    logic        start16, done16, busy16, err16;
    logic [31:0] res16;

    int n_pass = 0;
    int n_total = 0;

    logic [16:0] sb8[$];
    logic [32:0] sb16[$];
    logic [15:0] m_last8;
    logic [31:0] m_last16;

    param_alu #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .A(a8), .B(b8), .op(op8),
        .start(start8), .done(done8), .result(res8),
        .busy(busy8), .err(err8)
    );

    param_alu #(.WIDTH(16)) u16 (
        .clk(clk), .reset(reset), .A(a16), .B(b16), .op(op16),
        .start(start16), .done(done16), .result(res16),
        .busy(busy16), .err(err16)
    );

    function automatic logic [16:0] model8(input logic [2:0] o,
                                           input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic [15:0] prev);
        int s;
        case (o)
            3'b000: return {1'b0, prev};
            3'b001: return {1'b0, 16'(a) + 16'(b)};
            3'b010: return {1'b0, 8'h00, a & b};
            3'b011: return {1'b0, 8'h00, a ^ b};
            3'b100: return {1'b0, 16'(a) * 16'(b)};
            3'b101: begin
                s = int'(a) - int'(b);
                return {1'b0, s[15:0]};
            end
            default: return {1'b1, 16'h0000};
        endcase
    endfunction

    task automatic issue8(input logic [2:0] o, input logic [7:0] a,
                          input logic [7:0] b);
        logic [16:0] e;
        @(negedge clk);
        a8 = a; b8 = b; op8 = o; start8 = 1'b1;
        e = model8(o, a, b, m_last8);
        m_last8 = e[15:0];
        sb8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic issue16(input logic [2:0] o, input logic [15:0] a,
                           input logic [15:0] b);
        logic [32:0] e;
        @(negedge clk);
        a16 = a; b16 = b; op16 = o; start16 = 1'b1;
        if (o == 3'b100) e = {1'b0, 32'(a) * 32'(b)};
        else             e = {1'b0, m_last16};
        m_last16 = e[31:0];
        sb16.push_back(e);
        @(negedge clk);
        start16 = 1'b0;
    endtask

    task automatic wait8(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done8) begin
                lat = k;
                return;
            end
        end
    endtask

    task automatic wait16(output int lat);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done16) begin
                lat = k;
                return;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        a8 = '0; b8 = '0; op8 = '0; start8 = 1'b0;
        a16 = '0; b16 = '0; op16 = '0; start16 = 1'b0;
        m_last8 = '0; m_last16 = '0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({done8, busy8, err8} !== 3'b000)
            $display("FAIL reset_ctl8: got %b expected 000", {done8, busy8, err8});
        else n_pass++;
        n_total++;
        if (res8 !== 16'h0)
            $display("FAIL reset_res8: got %h expected 0000", res8);
        else n_pass++;
        n_total++;
        if ({done16, busy16, err16} !== 3'b000)
            $display("FAIL reset_ctl16: got %b expected 000", {done16, busy16, err16});
        else n_pass++;
        n_total++;
        if (res16 !== 32'h0)
            $display("FAIL reset_res16: got %h expected 00000000", res16);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_add;
        int lat;
        logic [16:0] e;
        issue8(3'b001, 8'hFF, 8'h01);
        n_total++;
        if (busy8 !== 1'b1) $display("FAIL add_busy: got %b expected 1", busy8);
        else n_pass++;
        wait8(lat);
        n_total++;
        if (lat != 1) $display("FAIL add_latency: got %0d expected 1", lat);
        else n_pass++;
        n_total++;
        if (busy8 !== 1'b0) $display("FAIL add_busy_at_done: got %b expected 0", busy8);
        else n_pass++;
        e = sb8.pop_front();
        n_total++;
        if ({err8, res8} !== e)
            $display("FAIL add_result: got %h expected %h", {err8, res8}, e);
        else n_pass++;
    endtask

    task automatic test_mul_ignore;
        int first;
        int ndone;
        bit busy_bad;
        logic [16:0] e;
        first = -1; ndone = 0; busy_bad = 0;
        issue8(3'b100, 8'hFF, 8'hFF);
        for (int k = 1; k <= 30; k++) begin
            if (k == 3) begin
                op8 = 3'b001; a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
            end
            @(negedge clk);
            if (k == 3) start8 = 1'b0;
            if (k < 8 && busy8 !== 1'b1) busy_bad = 1;
            if (done8) begin
                ndone++;
                if (first < 0) first = k;
                if (busy8) busy_bad = 1;
                if (sb8.size() == 0) e = 17'h1FFFF;
                else e = sb8.pop_front();
                n_total++;
                if ({err8, res8} !== e)
                    $display("FAIL mul_result: got %h expected %h", {err8, res8}, e);
                else n_pass++;
            end
        end
        n_total++;
        if (first != 8) $display("FAIL mul_latency: got %0d expected 8", first);
        else n_pass++;
        n_total++;
        if (ndone != 1) $display("FAIL mul_done_count: got %0d expected 1", ndone);
        else n_pass++;
        n_total++;
        if (busy_bad) $display("FAIL mul_busy: got bad expected high 8 cycles");
        else n_pass++;
    endtask

    task automatic test_sub_xor;
        logic [2:0] ops[3] = '{3'b101, 3'b101, 3'b011};
        logic [7:0] as[3] = '{8'd3, 8'd5, 8'hA5};
        logic [7:0] bs[3] = '{8'd5, 8'd3, 8'hFF};
        int lat;
        logic [16:0] e;
        for (int i = 0; i < 3; i++) begin
            issue8(ops[i], as[i], bs[i]);
            wait8(lat);
            n_total++;
            if (lat != 1) $display("FAIL subxor_lat%0d: got %0d expected 1", i, lat);
            else n_pass++;
            e = sb8.pop_front();
            n_total++;
            if ({err8, res8} !== e)
                $display("FAIL subxor_res%0d: got %h expected %h", i, {err8, res8}, e);
            else n_pass++;
        end
    endtask

    task automatic test_reserved;
        logic [2:0] ops[3] = '{3'b110, 3'b010, 3'b000};
        logic [7:0] as[3] = '{8'h12, 8'hF0, 8'h77};
        logic [7:0] bs[3] = '{8'h34, 8'h3C, 8'h88};
        int lat;
        logic [16:0] e;
        for (int i = 0; i < 3; i++) begin
            issue8(ops[i], as[i], bs[i]);
            wait8(lat);
            n_total++;
            if (lat != 1) $display("FAIL rsv_lat%0d: got %0d expected 1", i, lat);
            else n_pass++;
            e = sb8.pop_front();
            n_total++;
            if ({err8, res8} !== e)
                $display("FAIL rsv_res%0d: got %h expected %h", i, {err8, res8}, e);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] mask;
        logic [16:0] e;
        mask = '0;
        @(negedge clk);
        a8 = 8'd1; b8 = 8'd2; op8 = 3'b001; start8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            e = model8(3'b001, 8'd1, 8'd2, m_last8);
            m_last8 = e[15:0];
            sb8.push_back(e);
        end
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 6) start8 = 1'b0;
            mask[k-1] = done8;
            if (done8) begin
                if (sb8.size() == 0) e = 17'h1FFFF;
                else e = sb8.pop_front();
                n_total++;
                if ({err8, res8} !== e)
                    $display("FAIL b2b_res: got %h expected %h", {err8, res8}, e);
                else n_pass++;
            end
        end
        n_total++;
        if (mask !== 10'b00_0010_1010)
            $display("FAIL b2b_pattern: got %b expected 0000101010", mask);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int ndone;
        ndone = 0;
        issue8(3'b100, 8'h0F, 8'h0F);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_total++;
        if ({done8, busy8} !== 2'b00)
            $display("FAIL rstmid_ctl: got %b expected 00", {done8, busy8});
        else n_pass++;
        n_total++;
        if (res8 !== 16'h0)
            $display("FAIL rstmid_res: got %h expected 0000", res8);
        else n_pass++;
        sb8.delete();
        m_last8 = '0;
        @(negedge clk);
        reset = 1'b0;
        start8 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done8 || busy8) ndone++;
        end
        n_total++;
        if (ndone != 0) $display("FAIL rstmid_nodone: got %0d expected 0", ndone);
        else n_pass++;
    endtask

    task automatic test_w16;
        int lat;
        logic [32:0] e;
        issue16(3'b100, 16'hFFFF, 16'hFFFF);
        wait16(lat);
        n_total++;
        if (lat != 16) $display("FAIL w16_mul_lat: got %0d expected 16", lat);
        else n_pass++;
        e = sb16.pop_front();
        n_total++;
        if ({err16, res16} !== e)
            $display("FAIL w16_mul_res: got %h expected %h", {err16, res16}, e);
        else n_pass++;
        issue16(3'b000, 16'h1234, 16'h5678);
        wait16(lat);
        n_total++;
        if (lat != 1) $display("FAIL w16_nop_lat: got %0d expected 1", lat);
        else n_pass++;
        e = sb16.pop_front();
        n_total++;
        if ({err16, res16} !== e)
            $display("FAIL w16_nop_res: got %h expected %h", {err16, res16}, e);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul_ignore();
        test_sub_xor();
        test_reserved();
        test_back_to_back();
        test_reset_mid();
        test_w16();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/param_alu.md
Name: param_alu

Overview:
Parametrised successor of the team's tiny ALU. It accepts two WIDTH-bit operands and a 3-bit opcode on a start/done handshake, and returns a 2*WIDTH-bit result. Logic ops, ADD and SUB complete in one cycle. MUL is an iterative shift-add taking WIDTH cycles. New relative to the previous generation: width generalisation, SUB, busy and err outputs, and defined handling of reserved opcodes. The block sits under the bus-functional-model interface in the top-level bench and is a drop-in for the old ALU's port set.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32; result width is 2*WIDTH.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
A  input  WIDTH  operand A, unsigned; sampled only on the accepting edge.
B  input  WIDTH  operand B, unsigned; sampled only on the accepting edge.
op  input  3  opcode, sampled with A and B: 000 NOP, 001 ADD, 010 AND, 011 XOR, 100 MUL, 101 SUB, 110/111 reserved.
start  input  1  request; level-sampled each edge.
done  output  1  one-cycle pulse marking result and err valid.
result  output  2*WIDTH  operation result; holds its value until the next done.
busy  output  1  high while an accepted operation is in flight.
err  output  1  updated with done; 1 means reserved opcode.

Behaviour:
- Reset (asynchronous, immediate): done=0, busy=0, err=0, result=0, state=IDLE, mul counter=0. Reset mid-operation aborts it; no done follows reset release.
- States: IDLE, EXEC, MUL.
- Accept: at a rising edge with state=IDLE and start=1 (edge E0), latch A, B, op and set busy=1.
  - op=100: go to MUL.
  - Any other op: go to EXEC.
- start while busy=1: ignored. Operands and op are never re-sampled mid-operation.
- EXEC takes one cycle. At edge E1: done=1, busy=0, state=IDLE. result by opcode:
  - NOP: result unchanged, err=0.
  - ADD: zero-extend(A) + zero-extend(B), so the carry lands in bit WIDTH.
  - AND: zero-extend(A & B).
  - XOR: zero-extend(A ^ B).
  - SUB: (WIDTH+1)-bit signed difference A-B, sign-extended to 2*WIDTH.
  - Reserved: result=0, err=1.
- MUL (unsigned shift-add):
  - Per cycle: one multiplier bit (LSB first) is processed; the counter counts 0..WIDTH-1.
  - At edge E_WIDTH (the final bit): result=A*B, done=1, busy=0, err=0, state=IDLE.
  - Latency from accept: exactly WIDTH cycles.
  - result keeps its previous value during the multiply; the accumulator is internal.
- done is high for exactly one cycle per accepted operation and is never high while busy=1.
- Back-to-back: start=1 on the edge that asserts done is not accepted (state still EXEC/MUL). The earliest accept is the edge after done rises, which gives a minimum period of 2 cycles for single-cycle ops and WIDTH+1 for MUL.
- err is cleared to 0 on every non-reserved done.

Test Plan:
- WIDTH=8, ADD A=0xFF B=0x01 -> done exactly 1 cycle after accept; result=0x0100; err=0; busy high for 1 cycle.
- WIDTH=8, MUL A=0xFF B=0xFF -> busy high for 8 cycles; done at edge E8; result=0xFE01. A start asserted at cycle 3 with op=ADD is ignored, with no extra done.
- WIDTH=8, SUB A=3 B=5 -> result=0xFFFE. SUB A=5 B=3 -> result=0x0002. XOR A=0xA5 B=0xFF -> result=0x005A.
- WIDTH=8, op=110 A=0x12 B=0x34 -> done after 1 cycle, err=1, result=0x0000. A following AND A=0xF0 B=0x3C -> err=0, result=0x0030.
- WIDTH=8, reset asserted mid-MUL at cycle 4 -> result=0, busy=0, done=0 asynchronously. Release with start=0 -> no done for 20 cycles.
- WIDTH=16, MUL A=0xFFFF B=0xFFFF -> done at E16, result=0xFFFE0001. NOP issued next -> done after 1 cycle, result still 0xFFFE0001.
